magic_button_ctl: RTL and testbench
===================================

# magic_button_ctl

Conditions the physical Magic button and the keyboard Magic hotkey into the `magic_button` level consumed by the magic NMI controller. It also detects a long press and emits a one-cycle reset request. The block sits directly upstream of the magic controller and is clocked by clk28. It holds `magic_button` until the controller acknowledges by raising `magic_mode`, and gives up after a frame timeout.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 280000: clk28 cycles the synchronized pin must be stable before the debounced level changes (10 ms).
- LONG_FRAMES, 100: frame ticks of continuous debounced press before `reset_req` fires; range 1..255.
- REQ_TIMEOUT_FRAMES, 4: frame ticks spent in REQ without `magic_mode` before the request is dropped; range 1..255.

Ports:
- clk28  in  1  system clock, 28 MHz; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- n_magic_pin  in  1  raw button pin, active-low, asynchronous to clk28.
- ps2_magic  in  1  one-cycle hotkey pulse from the keyboard block, synchronous to clk28.
- n_int  in  1  frame interrupt, active-low, synchronous to clk28; its falling edge is the frame tick.
- magic_mode  in  1  acknowledge from the magic controller.
- magic_button  out  1  Magic request level to the magic controller; registered.
- reset_req  out  1  one-cycle long-press reset request; registered.

## Operation
- Synchronizer: two flops on `n_magic_pin`, both reset to 1 (released). `pressed_s` is the inverted second flop.
- Debouncer: holds the level `pressed_d` (reset 0) and a counter `deb_cnt` (reset 0).
  - While `pressed_s == pressed_d`, `deb_cnt` clears.
  - Otherwise `deb_cnt` increments.
  - When `deb_cnt == DEBOUNCE_CYCLES-1` and the levels still differ: `pressed_d <= pressed_s` and `deb_cnt <= 0`.
- Frame tick: `frame_tick = n_int_prev & ~n_int`. `n_int_prev` resets to 1.
- `press_evt` = `pressed_d` rising edge (registered previous value, reset 0) OR `ps2_magic`.
- Frame counter `fcnt`: 8 bits, saturating at 255. It clears on every state entry and increments on `frame_tick`.
- FSM states, all reset to IDLE:
  - IDLE:
    - `press_evt` with `magic_mode == 0` -> REQ.
    - `press_evt` with `magic_mode == 1` -> HELD (already in menu; only long-press counting).
  - REQ (`magic_button = 1`):
    - `magic_mode == 1` -> HELD if `pressed_d`, else IDLE.
    - `fcnt == REQ_TIMEOUT_FRAMES` -> IDLE.
    - `pressed_d` and `fcnt == LONG_FRAMES` -> LONG. This priority is the highest in REQ.
  - HELD:
    - `!pressed_d` -> IDLE.
    - `fcnt == LONG_FRAMES` -> LONG.
  - LONG: `!pressed_d` -> IDLE. No new event is accepted until IDLE is reached.
- `reset_req` pulses high for exactly one cycle on every entry into LONG.
- REQ entered via `ps2_magic` with the button released never reaches LONG; it uses the ack or timeout paths only.
- `ps2_magic` outside IDLE is ignored, not queued.
- Simultaneous `press_evt` and `magic_mode` rising in IDLE: `magic_mode` is sampled as 1, so the FSM goes to HELD.
- Simultaneous ack and timeout in REQ: the ack wins.

## Timing
- Reset values: `magic_button = 0`, `reset_req = 0`; state IDLE; all counters 0.
- Pin-to-`pressed_d` latency is 2 + DEBOUNCE_CYCLES clk28 cycles. A bounce shorter than DEBOUNCE_CYCLES produces no change.
- `pressed_d` rising -> `magic_button` high 2 cycles later: edge register, then FSM register.
- `ps2_magic` pulse -> `magic_button` high on the next cycle.
- `magic_mode` high in REQ -> `magic_button` low on the following cycle.
- LONG entry and `reset_req` assert in the same cycle as the qualifying `frame_tick`'s state update, i.e. one cycle after `frame_tick`.
- `rst_n` asserted mid-operation returns everything to reset values immediately. After release, a button still held produces a press only after a full debounce period.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=16, LONG_FRAMES=4, REQ_TIMEOUT_FRAMES=2; `n_int` low 1 cycle every 100 cycles.

- Bounce rejection: pin low for 10 cycles, high for 10, low for 10 -> `pressed_d` never rises; `magic_button` stays 0.
- Clean press with ack: pin low and held -> `magic_button` = 1 at cycle 2+16+2. Drive `magic_mode` = 1 -> `magic_button` = 0 next cycle. Release -> state IDLE; `reset_req` never fires.
- Timeout: `ps2_magic` pulse with `magic_mode` held 0 -> `magic_button` = 1 next cycle, then 0 one cycle after the 2nd frame tick.
- Long press: hold pin low, ack after 1 frame -> exactly one `reset_req` pulse one cycle after the 4th frame tick since HELD entry. Continued holding gives no further pulse; release then re-press gives a new request.
- Already in menu: `magic_mode` = 1 throughout; press -> `magic_button` stays 0. Hold for 4 frames -> `reset_req` pulses once.
- Async reset while in REQ: `rst_n` low for 3 cycles with the pin still low -> `magic_button` = 0 immediately. After release, `magic_button` re-asserts only after 2+16+2 cycles.

Source files
------------

// File: rtl/magic_button_ctl.sv
// rtl/magic_button_ctl.sv - Magic button conditioning, request handshake and long-press reset request
module magic_button_ctl #(
  parameter int unsigned DEBOUNCE_CYCLES    = 280000,
  parameter int unsigned LONG_FRAMES        = 100,
  parameter int unsigned REQ_TIMEOUT_FRAMES = 4
) (
  input  logic clk28,
  input  logic rst_n,
  input  logic n_magic_pin,
  input  logic ps2_magic,
  input  logic n_int,
  input  logic magic_mode,
  output logic magic_button,
  output logic reset_req
);

  // Debounce counter only ever needs to reach DEBOUNCE_CYCLES-1.
  localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] LONG_F = 8'(LONG_FRAMES);
  localparam logic [7:0] TMO_F  = 8'(REQ_TIMEOUT_FRAMES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HELD = 2'd2,
    LONG = 2'd3
  } state_t;

  logic             sync1_q, sync2_q;
  logic             pressed_s;
  logic             pressed_lvl_q, pressed_lvl_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             pressed_prev_q;
  logic             rise_q;
  logic             n_int_prev_q;
  logic             frame_tick;
  logic             press_evt;
  logic [7:0]       fcnt_q, fcnt_d, fcnt_inc;
  state_t           state_q, state_d;
  logic             magic_button_q;
  logic             reset_req_q;

  // Two-flop synchronizer for the asynchronous pin; idles released (high).
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= n_magic_pin;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_s = ~sync2_q;

  // Debouncer: the level follows the pin only after it has disagreed for a full period.
  always_comb begin
    pressed_lvl_d = pressed_lvl_q;
    deb_cnt_d     = '0;
    if (pressed_s != pressed_lvl_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        pressed_lvl_d = pressed_s;
        deb_cnt_d     = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // Debounced level and its stability counter.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      pressed_lvl_q <= 1'b0;
      deb_cnt_q     <= '0;
    end else begin
      pressed_lvl_q <= pressed_lvl_d;
      deb_cnt_q     <= deb_cnt_d;
    end
  end

  // Registered rising edge of the debounced level, plus previous frame interrupt level.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      pressed_prev_q <= 1'b0;
      rise_q         <= 1'b0;
      n_int_prev_q   <= 1'b1;
    end else begin
      pressed_prev_q <= pressed_lvl_q;
      rise_q         <= pressed_lvl_q & ~pressed_prev_q;
      n_int_prev_q   <= n_int;
    end
  end

  assign frame_tick = n_int_prev_q & ~n_int;
  assign press_evt  = rise_q | ps2_magic;

  // Thresholds compare against the count including the tick of this cycle,
  // so the state reacts on the same edge that samples the frame tick.
  assign fcnt_inc = (frame_tick && (fcnt_q != 8'hFF)) ? (fcnt_q + 8'd1) : fcnt_q;

  // Next-state logic; in REQ the long press outranks ack, and ack outranks timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (press_evt) begin
          state_d = magic_mode ? HELD : REQ;
        end
      end
      REQ: begin
        if (pressed_lvl_q && (fcnt_inc == LONG_F)) begin
          state_d = LONG;
        end else if (magic_mode) begin
          state_d = pressed_lvl_q ? HELD : IDLE;
        end else if (fcnt_inc == TMO_F) begin
          state_d = IDLE;
        end
      end
      HELD: begin
        if (!pressed_lvl_q) begin
          state_d = IDLE;
        end else if (fcnt_inc == LONG_F) begin
          state_d = LONG;
        end
      end
      LONG: begin
        if (!pressed_lvl_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame count restarts on every state change.
  assign fcnt_d = (state_d != state_q) ? 8'd0 : fcnt_inc;

  // State, frame counter and registered outputs.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      fcnt_q         <= 8'd0;
      magic_button_q <= 1'b0;
      reset_req_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      fcnt_q         <= fcnt_d;
      magic_button_q <= (state_d == REQ);
      reset_req_q    <= (state_d == LONG) && (state_q != LONG);
    end
  end

  assign magic_button = magic_button_q;
  assign reset_req    = reset_req_q;

endmodule

// File: tb/tb_magic_button_ctl.sv
// tb/tb_magic_button_ctl.sv - self-checking bench for magic_button_ctl
module tb_magic_button_ctl;

  localparam int D = 16;
  localparam int L = 4;
  localparam int T = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic n_magic_pin;
  logic ps2_magic;
  logic n_int;
  logic magic_mode;
  logic magic_button;
  logic reset_req;

  int total = 0;
  int bad = 0;
  int fc = 0;

  magic_button_ctl #(
    .DEBOUNCE_CYCLES(D),
    .LONG_FRAMES(L),
    .REQ_TIMEOUT_FRAMES(T)
  ) dut (
    .clk28(clk),
    .rst_n(rst_n),
    .n_magic_pin(n_magic_pin),
    .ps2_magic(ps2_magic),
    .n_int(n_int),
    .magic_mode(magic_mode),
    .magic_button(magic_button),
    .reset_req(reset_req)
  );

  always #5 clk = ~clk;

  // Reference model: button behaviour described by pin history, run lengths
  // and frames elapsed since the current mode began.
  typedef enum int {M_IDLE, M_REQ, M_HELD, M_LONG} mode_t;

  bit    pin_hist[$];
  bit    m_lvl;
  int    m_run;
  bit    m_lvl_old;
  bit    m_rise;
  bit    m_nint_old;
  mode_t m_mode;
  int    m_frames;
  bit    exp_mb;
  bit    exp_rr;

  task automatic model_reset();
    pin_hist.delete();
    pin_hist.push_back(1'b1);
    pin_hist.push_back(1'b1);
    m_lvl = 0; m_run = 0; m_lvl_old = 0; m_rise = 0;
    m_nint_old = 1; m_mode = M_IDLE; m_frames = 0;
    exp_mb = 0; exp_rr = 0;
  endtask

  task automatic model_step();
    bit    held_now;
    bit    evt;
    bit    tick;
    int    frames;
    mode_t nx;
    bit    seen;
    seen   = ~pin_hist[0];
    held_now = m_lvl;
    evt    = m_rise | ps2_magic;
    tick   = m_nint_old & ~n_int;
    frames = m_frames + (tick ? 1 : 0);
    if (frames > 255) frames = 255;
    nx = m_mode;
    case (m_mode)
      M_IDLE: if (evt) nx = magic_mode ? M_HELD : M_REQ;
      M_REQ: begin
        if (held_now && frames == L) nx = M_LONG;
        else if (magic_mode) nx = held_now ? M_HELD : M_IDLE;
        else if (frames == T) nx = M_IDLE;
      end
      M_HELD: begin
        if (!held_now) nx = M_IDLE;
        else if (frames == L) nx = M_LONG;
      end
      default: if (!held_now) nx = M_IDLE;
    endcase
    exp_rr = (nx == M_LONG) && (m_mode != M_LONG);
    exp_mb = (nx == M_REQ);
    m_frames = (nx != m_mode) ? 0 : frames;
    m_mode = nx;
    m_rise = held_now & ~m_lvl_old;
    m_lvl_old = held_now;
    if (seen != m_lvl) begin
      m_run++;
      if (m_run == D) begin
        m_lvl = seen;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    void'(pin_hist.pop_front());
    pin_hist.push_back(n_magic_pin);
    m_nint_old = n_int;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model follows the DUT edge, outputs compared at the falling edge,
  // then the frame interrupt schedule advances (low one cycle in every 100).
  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check("model_mb", int'(magic_button), int'(exp_mb));
    check("model_rr", int'(reset_req), int'(exp_rr));
    fc++;
    n_int = (fc % 100 == 0) ? 1'b0 : 1'b1;
  endtask

  typedef struct {
    logic pin;
    logic ps2;
    logic mm;
    int   ncyc;
    logic mb;
    logic rr;
  } vec_t;

  vec_t vecs[11];

  initial begin
    bit t;
    int ticks;
    int pulses;
    int pulse_tick;
    int pulse_on_tick;
    int mb_seen;
    bit last_mb;
    int pin_left;
    int mm_left;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 10, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 30, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 19, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 5,  1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1,  1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 30, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 5,  1'b0, 1'b0};

    rst_n = 1'b0; n_magic_pin = 1'b1; ps2_magic = 1'b0; n_int = 1'b1; magic_mode = 1'b0;
    model_reset();
    #1;
    check("reset_mb", int'(magic_button), 0);
    check("reset_rr", int'(reset_req), 0);
    repeat (3) cyc();
    rst_n = 1'b1;

    // Bounce rejection, clean press, ack, release.
    for (int i = 0; i < 11; i++) begin
      n_magic_pin = vecs[i].pin;
      ps2_magic   = vecs[i].ps2;
      magic_mode  = vecs[i].mm;
      repeat (vecs[i].ncyc) cyc();
      check($sformatf("vec%0d_mb", i), int'(magic_button), int'(vecs[i].mb));
      check($sformatf("vec%0d_rr", i), int'(reset_req), int'(vecs[i].rr));
    end

    // Keyboard request timing out after two frames.
    if (!n_int) cyc();
    ps2_magic = 1'b1;
    cyc();
    ps2_magic = 1'b0;
    check("kbd_req", int'(magic_button), 1);
    ticks = 0; last_mb = 0;
    for (int k = 0; k < 400 && ticks < 2; k++) begin
      t = ~n_int;
      last_mb = magic_button;
      cyc();
      if (t) ticks++;
    end
    check("timeout_ticks", ticks, 2);
    check("timeout_hold", int'(last_mb), 1);
    check("timeout_drop", int'(magic_button), 0);

    // Long press: ack after one frame, then four frames held.
    n_magic_pin = 1'b0;
    repeat (20) cyc();
    check("long_req", int'(magic_button), 1);
    for (int k = 0; k < 200; k++) begin
      t = ~n_int;
      cyc();
      if (t) break;
    end
    magic_mode = 1'b1;
    cyc();
    check("long_ack", int'(magic_button), 0);
    ticks = 0; pulses = 0; pulse_tick = -1; pulse_on_tick = 0;
    for (int k = 0; k < 600; k++) begin
      t = ~n_int;
      cyc();
      if (t) ticks++;
      if (reset_req) begin
        pulses++;
        pulse_tick = ticks;
        pulse_on_tick = int'(t);
      end
    end
    check("long_pulses", pulses, 1);
    check("long_pulse_frame", pulse_tick, 4);
    check("long_pulse_edge", pulse_on_tick, 1);
    n_magic_pin = 1'b1; magic_mode = 1'b0;
    repeat (40) cyc();
    check("long_release", int'(magic_button), 0);
    n_magic_pin = 1'b0;
    repeat (19) cyc();
    check("repress_wait", int'(magic_button), 0);
    cyc();
    check("repress_req", int'(magic_button), 1);
    magic_mode = 1'b1;
    cyc();
    n_magic_pin = 1'b1;
    repeat (40) cyc();
    magic_mode = 1'b0;
    cyc();

    // Already in the menu: no request, long press still reported once.
    magic_mode = 1'b1;
    n_magic_pin = 1'b0;
    ticks = 0; pulses = 0; pulse_tick = -1; pulse_on_tick = 0; mb_seen = 0;
    for (int k = 0; k < 600; k++) begin
      t = ~n_int;
      cyc();
      if (k >= 20 && t) ticks++;
      if (magic_button) mb_seen++;
      if (reset_req) begin
        pulses++;
        pulse_tick = ticks;
        pulse_on_tick = int'(t);
      end
    end
    check("menu_mb", mb_seen, 0);
    check("menu_pulses", pulses, 1);
    check("menu_pulse_frame", pulse_tick, 4);
    check("menu_pulse_edge", pulse_on_tick, 1);
    n_magic_pin = 1'b1;
    repeat (40) cyc();
    magic_mode = 1'b0;
    cyc();

    // Asynchronous reset while requesting, pin still held.
    n_magic_pin = 1'b0;
    repeat (22) cyc();
    check("rst_pre_req", int'(magic_button), 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mb_now", int'(magic_button), 0);
    check("rst_rr_now", int'(reset_req), 0);
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (19) cyc();
    check("rst_rearm_wait", int'(magic_button), 0);
    cyc();
    check("rst_rearm_req", int'(magic_button), 1);
    magic_mode = 1'b1;
    cyc();
    n_magic_pin = 1'b1;
    repeat (40) cyc();
    magic_mode = 1'b0;
    cyc();

    // Randomized traffic against the model.
    pin_left = 0; mm_left = 0;
    for (int k = 0; k < 6000; k++) begin
      if (pin_left == 0) begin
        n_magic_pin = ~n_magic_pin;
        pin_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 600)) : int'($urandom_range(1, 40));
      end
      if (mm_left == 0) begin
        magic_mode = ~magic_mode;
        mm_left = int'($urandom_range(20, 300));
      end
      ps2_magic = ($urandom_range(0, 29) == 0);
      cyc();
      pin_left--;
      mm_left--;
    end
    ps2_magic = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
